// File: rtl/jk_excitation_driver.sv
// JK excitation driver: turns target next-Q values into one-cycle J/K drives,
// then checks the driven flop's Q and keeps mismatch statistics.
module jk_excitation_driver #(
  parameter int unsigned DC_MODE   = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_valid,
  input  logic                 tgt_q,
  output logic                 tgt_ready,
  output logic                 j,
  output logic                 k,
  input  logic                 q_fb,
  input  logic                 clr_err,
  output logic                 done_valid,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 sticky_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic DC = (DC_MODE != 0);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  state_e               state_q, state_d;
  logic                 tq_q, tq_d;
  logic                 j_q, j_d;
  logic                 k_q, k_d;
  logic                 done_q, done_d;
  logic                 mis_q, mis_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 stk_q, stk_d;
  logic                 err_fire;

  assign err_fire = (state_q == CHECK) && (q_fb != tq_q);

  always_comb begin
    state_d = state_q;
    tq_d    = tq_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tq_d    = tgt_q;
          // Excitation table; the don't-care side takes DC
          j_d     = q_fb ? DC : tgt_q;
          k_d     = q_fb ? ~tgt_q : DC;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        done_d  = 1'b1;
        mis_d   = err_fire;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    stk_d = stk_q;
    if (clr_err) begin
      cnt_d = err_fire ? CNT_ONE : '0;
      stk_d = err_fire;
    end else if (err_fire) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      stk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tq_q    <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tq_q    <= tq_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      stk_q   <= stk_d;
    end
  end

  assign tgt_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign j          = j_q;
  assign k          = k_q;
  assign done_valid = done_q;
  assign mismatch   = mis_q;
  assign err_cnt    = cnt_q;
  assign sticky_err = stk_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: two instances (DC_MODE 0/W=8 and
// DC_MODE 1/W=2) driving behavioural JK flops with a stuck-at-0 option.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tgt_valid = 1'b0;
  logic tgt_q = 1'b0;
  logic clr_err = 1'b0;
  logic stuck = 1'b0;

  logic rdy0, j0, k0, done0, mis0, stk0, busy0;
  logic rdy1, j1, k1, done1, mis1, stk1, busy1;
  logic [7:0] err0;
  logic [1:0] err1;
  logic fq0, fq1;
  logic qfb0, qfb1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign qfb0 = stuck ? 1'b0 : fq0;
  assign qfb1 = stuck ? 1'b0 : fq1;

  // Ideal JK flops
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq0 <= 1'b0;
      fq1 <= 1'b0;
    end else begin
      fq0 <= (j0 & ~fq0) | (~k0 & fq0);
      fq1 <= (j1 & ~fq1) | (~k1 & fq1);
    end
  end

  jk_excitation_driver #(.DC_MODE(0), .ERR_CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_q(tgt_q),
    .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(qfb0), .clr_err(clr_err),
    .done_valid(done0), .mismatch(mis0), .err_cnt(err0),
    .sticky_err(stk0), .busy(busy0)
  );

  jk_excitation_driver #(.DC_MODE(1), .ERR_CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_q(tgt_q),
    .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(qfb1), .clr_err(clr_err),
    .done_valid(done1), .mismatch(mis1), .err_cnt(err1),
    .sticky_err(stk1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic t, input logic [1:0] e0,
                      input logic [1:0] e1, input logic em,
                      input logic clr);
    int n;
    n = 0;
    while (!rdy0 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready", {31'd0, rdy0}, 1);
    tgt_valid = 1'b1;
    tgt_q = t;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("jk0", {30'd0, j0, k0}, {30'd0, e0});
    check("jk1", {30'd0, j1, k1}, {30'd0, e1});
    check("busy", {30'd0, busy0, busy1}, 2'b11);
    check("rdy_lo", {30'd0, rdy0, rdy1}, 0);
    @(posedge clk); #1;
    check("hold_jk", {28'd0, j0, k0, j1, k1}, 0);
    check("early_done", {30'd0, done0, done1}, 0);
    clr_err = clr;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("done", {30'd0, done0, done1}, 2'b11);
    check("mis", {30'd0, mis0, mis1}, {30'd0, em, em});
  endtask

  logic       t1_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] t1_e0[4] = '{2'b10, 2'b00, 2'b01, 2'b00};
  logic [1:0] t2_e1[4] = '{2'b11, 2'b10, 2'b11, 2'b01};
  logic [1:0] t4_c1[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    int hs, dn, mm;
    logic [9:0] rpat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_jk", {28'd0, j0, k0, j1, k1}, 0);
    check("rst_done", {28'd0, done0, mis0, done1, mis1}, 0);
    check("rst_err0", {24'd0, err0}, 0);
    check("rst_err1", {30'd0, err1}, 0);
    check("rst_stk", {30'd0, stk0, stk1}, 0);
    check("rst_busy", {30'd0, busy0, busy1}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", {30'd0, rdy0, rdy1}, 2'b11);

    // T1 / T2: ideal flops, targets 1,1,0,0
    for (int i = 0; i < 4; i++) begin
      send(t1_t[i], t1_e0[i], t2_e1[i], 1'b0, 1'b0);
      check("q_follow", {30'd0, fq0, fq1}, {30'd0, t1_t[i], t1_t[i]});
    end
    check("t1_err0", {24'd0, err0}, 0);
    check("t1_err1", {30'd0, err1}, 0);

    // T5: valid held 10 cycles, alternating target
    hs = 0; dn = 0; mm = 0; rpat = '0;
    tgt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rpat[i] = rdy0;
      if (rdy0) hs++;
      tgt_q = i[0];
      @(posedge clk); #1;
      if (done0) dn++;
      if (done0 && mis0) mm++;
    end
    tgt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done0) dn++;
      if (done0 && mis0) mm++;
    end
    check("t5_rpat", {22'd0, rpat}, 32'b1001001001);
    check("t5_hs", hs, 4);
    check("t5_done", dn, 4);
    check("t5_mis", mm, 0);

    // T3: stuck-at-0, target 1, then clear
    stuck = 1'b1;
    send(1'b1, 2'b10, 2'b11, 1'b1, 1'b0);
    check("t3_err0", {24'd0, err0}, 1);
    check("t3_err1", {30'd0, err1}, 1);
    check("t3_stk", {30'd0, stk0, stk1}, 2'b11);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t3_clr_err0", {24'd0, err0}, 0);
    check("t3_clr_err1", {30'd0, err1}, 0);
    check("t3_clr_stk", {30'd0, stk0, stk1}, 0);

    // T4: saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 2'b10, 2'b11, 1'b1, 1'b0);
      check("t4_err1", {30'd0, err1}, {30'd0, t4_c1[i]});
      check("t4_err0", {24'd0, err0}, i + 1);
      check("t4_stk", {30'd0, stk0, stk1}, 2'b11);
    end

    // clr_err on the same edge as a mismatch keeps the new error
    send(1'b1, 2'b10, 2'b11, 1'b1, 1'b1);
    check("same_err0", {24'd0, err0}, 1);
    check("same_err1", {30'd0, err1}, 1);
    check("same_stk", {30'd0, stk0, stk1}, 2'b11);

    // T6: reset during DRIVE
    tgt_valid = 1'b1;
    tgt_q = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("t6_j", {30'd0, j0, j1}, 2'b11);
    #1 rst = 1'b0;
    #1;
    check("t6_jk0", {28'd0, j0, k0, j1, k1}, 0);
    check("t6_busy", {30'd0, busy0, busy1}, 0);
    check("t6_err0", {24'd0, err0}, 0);
    check("t6_err1", {30'd0, err1}, 0);
    check("t6_stk", {30'd0, stk0, stk1}, 0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) dn++;
    end
    rst = 1'b1;
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) dn++;
    end
    check("t6_nodone", dn, 0);
    check("t6_rdy", {30'd0, rdy0, rdy1}, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
